// File: rtl/dir_scheduler_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dir_scheduler_pkg : direction encodings and helpers for the snake     |
// | move-direction scheduler.           Revision: 1.0                     |
// +----------------------------------------------------------------------+
package dir_scheduler_pkg;

    typedef logic [1:0] dir_t;

    localparam dir_t TOP_DIR   = 2'd0;
    localparam dir_t DOWN_DIR  = 2'd1;
    localparam dir_t LEFT_DIR  = 2'd2;
    localparam dir_t RIGHT_DIR = 2'd3;

    // Opposite direction by explicit comparison, so any encoding change stays safe.
    function automatic dir_t opp_dir(input dir_t d);
        dir_t r;
        if (d == TOP_DIR)       r = DOWN_DIR;
        else if (d == DOWN_DIR) r = TOP_DIR;
        else if (d == LEFT_DIR) r = RIGHT_DIR;
        else                    r = LEFT_DIR;
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dir_scheduler_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dir_scheduler_if : key/tick inputs and direction outputs of the       |
// | scheduler.                          Revision: 1.0                     |
// +----------------------------------------------------------------------+
interface dir_scheduler_if #(
    parameter int DEPTH = 4
);
    logic                           iK_Left;
    logic                           iK_Right;
    logic                           iK_Up;
    logic                           iK_Down;
    logic                           iTick;
    logic                           iEnable;
    logic                           iClear;
    logic [1:0]                     oDirection;
    logic                           oStep;
    logic [$clog2(DEPTH+1)-1:0]     oCount;
    logic                           oOverflow;

    modport master (
        output iK_Left, iK_Right, iK_Up, iK_Down, iTick, iEnable, iClear,
        input  oDirection, oStep, oCount, oOverflow
    );

    modport slave (
        input  iK_Left, iK_Right, iK_Up, iK_Down, iTick, iEnable, iClear,
        output oDirection, oStep, oCount, oOverflow
    );
endinterface
`default_nettype wire

// File: rtl/dir_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dir_fifo : 2-bit wide direction queue, synchronous push/pop/flush.    |
// |                                     Revision: 1.0                     |
// +----------------------------------------------------------------------+
module dir_fifo #(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH+1)
) (
    input  wire logic           iClk,
    input  wire logic           iRst_n,
    input  wire logic           iClear,
    input  wire logic           iPush,
    input  wire logic           iPop,
    input  wire logic [1:0]     iData,
    output logic                oFull,
    output logic                oEmpty,
    output logic [CW-1:0]       oCount,
    output logic [1:0]          oHead,
    output logic [1:0]          oTail
);
    logic [1:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_pop_ok;
    logic          w_push_ok;

    assign oFull     = (r_count == CW'(DEPTH));
    assign oEmpty    = (r_count == '0);
    assign oCount    = r_count;
    assign oHead     = r_mem[r_rd_ptr];
    assign oTail     = r_mem[r_wr_ptr - AW'(1)];

    // A pop in the same cycle frees a slot, so a full queue can still accept a push.
    assign w_pop_ok  = iPop && !oEmpty;
    assign w_push_ok = iPush && (!oFull || w_pop_ok);

    always_ff @(posedge iClk) begin
        if (w_push_ok && !iClear)
            r_mem[r_wr_ptr] <= iData;
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (iClear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: rtl/dir_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dir_scheduler : queues debounced key presses, applies one direction   |
// | per game tick.                      Revision: 1.0                     |
// +----------------------------------------------------------------------+
module dir_scheduler
    import dir_scheduler_pkg::*;
#(
    parameter int DEPTH         = 4,
    parameter int ALLOW_REVERSE = 0
) (
    input  wire logic          iClk,
    input  wire logic          iRst_n,
    dir_scheduler_if.slave     bus
);
    localparam int CW = $clog2(DEPTH+1);

    logic          w_active;
    logic          w_tick;
    logic          w_pop;
    logic          w_key_valid;
    dir_t          w_cand;
    dir_t          w_tail;
    logic          w_reject;
    logic          w_push_req;
    logic          w_drop;
    logic          w_full;
    logic          w_empty;
    logic [CW-1:0] w_count;
    dir_t          w_head;
    dir_t          w_fifo_tail;
    dir_t          r_direction;
    logic          r_step;
    logic          r_overflow;

    assign w_active    = bus.iEnable && !bus.iClear;
    assign w_tick      = w_active && bus.iTick;
    assign w_pop       = w_tick && !w_empty;
    assign w_key_valid = bus.iK_Up || bus.iK_Down || bus.iK_Left || bus.iK_Right;

    always_comb begin
        w_cand = RIGHT_DIR;
        if (bus.iK_Up)        w_cand = TOP_DIR;
        else if (bus.iK_Down) w_cand = DOWN_DIR;
        else if (bus.iK_Left) w_cand = LEFT_DIR;
    end

    // The pre-pop tail equals the post-pop tail: a popped last entry becomes r_direction.
    assign w_tail     = w_empty ? r_direction : w_fifo_tail;
    assign w_reject   = (w_cand == w_tail) ||
                        ((ALLOW_REVERSE == 0) && (w_cand == opp_dir(w_tail)));
    assign w_push_req = w_active && w_key_valid && !w_reject;
    assign w_drop     = w_push_req && w_full && !w_pop;

    dir_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .iClk   (iClk),
        .iRst_n (iRst_n),
        .iClear (bus.iClear),
        .iPush  (w_push_req),
        .iPop   (w_pop),
        .iData  (w_cand),
        .oFull  (w_full),
        .oEmpty (w_empty),
        .oCount (w_count),
        .oHead  (w_head),
        .oTail  (w_fifo_tail)
    );

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            r_direction <= TOP_DIR;
            r_step      <= 1'b0;
            r_overflow  <= 1'b0;
        end else if (bus.iClear) begin
            r_direction <= TOP_DIR;
            r_step      <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            if (w_pop) r_direction <= w_head;
            r_step     <= w_tick;
            r_overflow <= r_overflow || w_drop;
        end
    end

    assign bus.oDirection = r_direction;
    assign bus.oStep      = r_step;
    assign bus.oCount     = w_count;
    assign bus.oOverflow  = r_overflow;
endmodule
`default_nettype wire

// File: doc/dir_scheduler.md
# dir_scheduler

Move-direction scheduler for the snake game. It sits between the four debounced key-flag outputs of the `key_filter` instances and the game-step logic, and replaces the bare direction register. Key presses go into a small FIFO, with reversals and duplicates rejected. Exactly one queued direction is applied per game tick, so fast key sequences (e.g. up-then-left within one step) are not lost and cannot cause a 180° self-collision.

## Interface
- `DEPTH`, 4: queue entries; power of two, ≥2.
- `ALLOW_REVERSE`, 0: 1 disables the opposite-direction rejection.
- `iClk`, in, 1: system clock.
- `iRst_n`, in, 1: reset. Asynchronous assert, active-low.
- `iK_Left`, `iK_Right`, `iK_Up`, `iK_Down`, in, 1 each: debounced key flags, each a single-cycle pulse.
- `iTick`, in, 1: game-step strobe, single-cycle pulse.
- `iEnable`, in, 1: game running. Low means paused.
- `iClear`, in, 1: synchronous flush / new game.
- `oDirection`, out, 2: current move direction, `TOP_DIR`/`DOWN_DIR`/`LEFT_DIR`/`RIGHT_DIR` from define.vh.
- `oStep`, out, 1: one-cycle pulse, the cycle after an accepted tick.
- `oCount`, out, $clog2(DEPTH+1): queued entries.
- `oOverflow`, out, 1: sticky flag, set when a valid key was dropped because the queue was full.

## Operation
- Reset values: `oDirection`=`TOP_DIR`, `oCount`=0, `oStep`=0, `oOverflow`=0, queue pointers 0.
- **Key select:** when several flags arrive in the same cycle, one candidate is chosen with priority up > down > left > right. The others are discarded.
- **Tail:** the last queued entry if `oCount`>0, otherwise `oDirection`.
- **Reject rules:**
  - A candidate equal to the tail is rejected.
  - A candidate equal to opposite(tail) is rejected when `ALLOW_REVERSE`=0.
  - Rejected keys do not touch `oOverflow`.
- **Enqueue:** a surviving candidate is pushed if not full. If full and no pop happens this cycle, the key is dropped and `oOverflow` is set.
- **Pop:** `iTick`=1 and `iEnable`=1 with `oCount`>0 moves the head entry to `oDirection`. If the queue is empty, `oDirection` holds. `oStep` pulses on every accepted tick, empty or not.
- **Pause:** while `iEnable`=0, ticks and key flags are both ignored and the queue is frozen.
- **Simultaneous key + tick:**
  - The pop is taken first, then the tail is evaluated against the post-pop state. The tail value is unchanged either way, because a popped last entry becomes `oDirection`.
  - With the queue full, the pop frees a slot, the key is accepted, `oCount` stays the same, and there is no overflow.
  - With the queue empty, the key is enqueued, not applied directly. It is applied at the next tick.
- **`iClear`:** has priority over everything. It empties the queue, sets `oDirection`=`TOP_DIR`, clears `oOverflow`, and forces `oStep`=0 next cycle.
- **Wrap-around:** read and write pointers wrap modulo `DEPTH`. `oCount` saturates at `DEPTH` and never exceeds it.
- **Reset mid-operation:** outputs return to their reset values immediately; no partial state survives.

## Timing
- Key flag in cycle n: `oCount` reflects it in n+1.
- Tick in cycle n: `oDirection` is updated in n+1 and `oStep` is high in n+1 only.
- Back-to-back ticks: one pop per tick, one per cycle.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Structure
- **define.vh:**
  - Existing direction macros.
  - Add `` `OPP_DIR(d) ``, mapping TOP↔DOWN and LEFT↔RIGHT. It is built by explicit comparison with the macros, not bit arithmetic.
- **Sub-module `dir_fifo`:**
  - 2-bit wide, `DEPTH` deep, synchronous push/pop.
  - Outputs: `full`, `empty`, count, head and tail data.
  - Same-cycle push+pop is legal when full or empty.
- **`dir_scheduler`:** holds the key select, tail compare, tick/enable gating, `oDirection`/`oStep`/`oOverflow` registers, and the `dir_fifo` instance.

## Test plan
- Reset, then tick with no keys → `oDirection`=`TOP_DIR`, `oStep` pulses in n+1, `oCount`=0.
- From TOP: `iK_Left` pulse, then `iK_Down` pulse, then two ticks → `oCount`=2; `oDirection` becomes LEFT after the 1st tick and DOWN after the 2nd.
- From TOP: `iK_Down` pulse → rejected, `oCount`=0, `oOverflow`=0. Repeat with `ALLOW_REVERSE`=1 → `oCount`=1.
- `DEPTH`=4: alternately press LEFT, UP, RIGHT, UP, then LEFT → first four queued, fifth dropped, `oOverflow`=1. A tick and a key in the same cycle while full → `oCount` stays 4, no further overflow.
- `iEnable`=0 with `oCount`=2 and ticks applied → no pop, `oStep`=0. Raise `iEnable` → resumes with one pop per tick.
- `iClear` asserted in the same cycle as a key and a tick → next cycle `oCount`=0, `oDirection`=`TOP_DIR`, `oStep`=0, `oOverflow`=0. `iRst_n` pulsed mid-queue → same values, asynchronously.
